// File: rtl/ahb_pkg.sv
// Shared AHB definitions: HTRANS encodings, master id type, arbiter state.
// Optional feature macro: AHB_ARB_LOCK_EN (adds the LOCKED arbiter state).
package ahb_pkg;

   typedef enum logic [1:0] {
      HTRANS_IDLE   = 2'b00,
      HTRANS_BUSY   = 2'b01,
      HTRANS_NONSEQ = 2'b10,
      HTRANS_SEQ    = 2'b11
   } htrans_e;

   typedef logic [1:0] master_id_t;

`ifdef AHB_ARB_LOCK_EN
   typedef enum logic [1:0] {
      ST_PARK,
      ST_OWNED,
      ST_LOCKED
   } arb_state_e;
`else
   typedef enum logic [0:0] {
      ST_PARK,
      ST_OWNED
   } arb_state_e;
`endif

endpackage

// File: rtl/ahb_arbiter_if.sv
// Arbiter request/grant bundle. The slave modport is the arbiter's view,
// the master modport is the requesters' view.
// Optional feature macro: AHB_ARB_LOCK_EN (adds hlock).
interface ahb_arbiter_if
   import ahb_pkg::*;
#(
   parameter int NUM_MASTERS = 4
) ();

   logic [NUM_MASTERS-1:0] hbusreq;
`ifdef AHB_ARB_LOCK_EN
   logic [NUM_MASTERS-1:0] hlock;
`endif
   logic [1:0]             htrans;
   logic                   hready;
   logic [NUM_MASTERS-1:0] hgrant;
   master_id_t             hmaster;
   logic                   hmastlock;

   modport slave (
      input  hbusreq,
`ifdef AHB_ARB_LOCK_EN
      input  hlock,
`endif
      input  htrans,
      input  hready,
      output hgrant,
      output hmaster,
      output hmastlock
   );

   modport master (
      output hbusreq,
`ifdef AHB_ARB_LOCK_EN
      output hlock,
`endif
      output htrans,
      output hready,
      input  hgrant,
      input  hmaster,
      input  hmastlock
   );

endinterface

// File: rtl/ahb_rr_picker.sv
// Combinational round-robin picker: searches from last_id+1 upward
// (wrapping), so last_id itself is considered only after all others.
module ahb_rr_picker
   import ahb_pkg::*;
#(
   parameter int NUM_MASTERS = 4
) (
   input  logic [NUM_MASTERS-1:0] req,
   input  master_id_t             last_id,
   output logic [NUM_MASTERS-1:0] grant,
   output master_id_t             id,
   output logic                   valid
);

   int unsigned idx;

   // First requester found walking forward from the previous owner.
   always_comb begin
      grant = '0;
      id    = '0;
      valid = 1'b0;
      idx   = 0;
      for (int unsigned i = 1; i <= NUM_MASTERS; i++) begin
         idx = (32'(last_id) + i) % NUM_MASTERS;
         if (!valid && req[idx]) begin
            grant[idx] = 1'b1;
            id         = master_id_t'(idx);
            valid      = 1'b1;
         end
      end
   end

endmodule

// File: rtl/ahb_arbiter.sv
// Round-robin AHB bus arbiter with burst hold, tenure limit and parking.
// Optional feature macro: AHB_ARB_LOCK_EN (hlock port, LOCKED state,
// registered hmastlock); without it hmastlock is tied low.
module ahb_arbiter
   import ahb_pkg::*;
#(
   parameter int NUM_MASTERS    = 4,
   parameter int ID_W           = 2,
   parameter int DEFAULT_MASTER = 0,
   parameter int MAX_TENURE     = 16
) (
   input logic          hclk,
   input logic          hresetn,
   ahb_arbiter_if.slave bus
);

   localparam master_id_t             DEF_ID     = master_id_t'(DEFAULT_MASTER);
   localparam logic [NUM_MASTERS-1:0] DEF_GRANT  = NUM_MASTERS'(1) << DEFAULT_MASTER;
   localparam logic [7:0]             TENURE_MAX = 8'(MAX_TENURE);

   arb_state_e             state_q, state_n;
   master_id_t             owner_q, owner_n;
   logic [NUM_MASTERS-1:0] grant_q, grant_n;
   logic [7:0]             tenure_q, tenure_n;
   logic [ID_W-1:0]        hmaster_q, hmaster_n;
   logic                   hmastlock_q, hmastlock_n;

   logic [NUM_MASTERS-1:0] pick_grant;
   master_id_t             pick_id;
   logic                   pick_valid;

   logic seq_busy, beat, own_req, others, lock_hold, hold;

   // The owner id doubles as the round-robin pointer: it is updated on
   // exactly the grant changes that move the pointer.
   ahb_rr_picker #(
      .NUM_MASTERS(NUM_MASTERS)
   ) u_picker (
      .req    (bus.hbusreq),
      .last_id(owner_q),
      .grant  (pick_grant),
      .id     (pick_id),
      .valid  (pick_valid)
   );

   // Arbitration state, grant, tenure and address-phase owner registers.
   always_ff @(posedge hclk or negedge hresetn) begin
      if (!hresetn) begin
         state_q     <= ST_PARK;
         owner_q     <= DEF_ID;
         grant_q     <= DEF_GRANT;
         tenure_q    <= '0;
         hmaster_q   <= ID_W'(DEFAULT_MASTER);
         hmastlock_q <= 1'b0;
      end else begin
         state_q     <= state_n;
         owner_q     <= owner_n;
         grant_q     <= grant_n;
         tenure_q    <= tenure_n;
         hmaster_q   <= hmaster_n;
         hmastlock_q <= hmastlock_n;
      end
   end

   // Decision logic: evaluated only when hready completes a transfer.
   always_comb begin
      seq_busy = (bus.htrans == HTRANS_SEQ) || (bus.htrans == HTRANS_BUSY);
      beat     = (bus.htrans == HTRANS_NONSEQ) || (bus.htrans == HTRANS_SEQ);
      own_req  = |(bus.hbusreq & grant_q);
      others   = |(bus.hbusreq & ~grant_q);
      lock_hold = 1'b0;
`ifdef AHB_ARB_LOCK_EN
      lock_hold = (state_q != ST_PARK) && (|(bus.hlock & grant_q));
`endif
      hold = seq_busy || lock_hold ||
             (own_req && ((tenure_q < TENURE_MAX) || !others));

      state_n     = state_q;
      owner_n     = owner_q;
      grant_n     = grant_q;
      tenure_n    = tenure_q;
      hmaster_n   = hmaster_q;
      hmastlock_n = 1'b0;
`ifdef AHB_ARB_LOCK_EN
      hmastlock_n = hmastlock_q;
`endif

      if (bus.hready) begin
         hmaster_n = owner_q;
`ifdef AHB_ARB_LOCK_EN
         hmastlock_n = |(bus.hlock & grant_q);
`endif
         if (hold) begin
            if (beat && (tenure_q < TENURE_MAX)) tenure_n = tenure_q + 8'd1;
`ifdef AHB_ARB_LOCK_EN
            if (lock_hold)                                state_n = ST_LOCKED;
            else if ((state_q == ST_LOCKED) && seq_busy)  state_n = ST_LOCKED;
            else if (own_req)                             state_n = ST_OWNED;
`else
            if (own_req) state_n = ST_OWNED;
`endif
         end else if (pick_valid) begin
            // Hold failed, so the picker never returns the current owner.
            owner_n  = pick_id;
            grant_n  = pick_grant;
            state_n  = ST_OWNED;
            tenure_n = '0;
         end else begin
            owner_n = DEF_ID;
            grant_n = DEF_GRANT;
            state_n = ST_PARK;
            if (owner_q != DEF_ID)                       tenure_n = '0;
            else if (beat && (tenure_q < TENURE_MAX))    tenure_n = tenure_q + 8'd1;
         end
      end
   end

   assign bus.hgrant  = grant_q;
   assign bus.hmaster = hmaster_q;
`ifdef AHB_ARB_LOCK_EN
   assign bus.hmastlock = hmastlock_q;
`else
   assign bus.hmastlock = 1'b0;
`endif

endmodule

// File: tb/tb_ahb_arbiter.sv
// Self-checking bench for ahb_arbiter: directed vector table, hand-written
// tenure/reset/lock sequences and random traffic against a reference model.
// Optional feature macro: AHB_ARB_LOCK_EN (enables lock sequences).
module tb_ahb_arbiter;
   import ahb_pkg::*;

   localparam int N    = 4;
   localparam int MAXT = 16;
   localparam int DEFM = 0;
`ifdef AHB_ARB_LOCK_EN
   localparam bit LOCK_EN = 1'b1;
`else
   localparam bit LOCK_EN = 1'b0;
`endif

   logic hclk = 1'b0;
   logic hresetn;
   always #5 hclk = ~hclk;

   ahb_arbiter_if #(.NUM_MASTERS(N)) bus ();

   ahb_arbiter #(
      .NUM_MASTERS(N),
      .ID_W(2),
      .DEFAULT_MASTER(DEFM),
      .MAX_TENURE(MAXT)
   ) dut (
      .hclk(hclk),
      .hresetn(hresetn),
      .bus(bus)
   );

   int checks = 0;
   int errors = 0;

   // Reference model: owner id, tenure, delayed address-phase owner.
   int m_owner, m_tenure, m_hmaster;
   bit m_mlock, m_parked;

   typedef struct {
      logic [3:0] req;
      logic [1:0] trans;
      logic       ready;
      logic [3:0] exp_grant;
      logic [1:0] exp_hmaster;
   } vec_t;

   vec_t vecs[13];

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
      end
   endtask

   task automatic model_reset();
      m_owner   = DEFM;
      m_tenure  = 0;
      m_hmaster = DEFM;
      m_mlock   = 1'b0;
      m_parked  = 1'b1;
   endtask

   task automatic model_edge(input logic [3:0] r, input logic [1:0] t, input logic rd,
                             input logic [3:0] lk_in);
      logic [3:0] lk;
      bit seqbusy, counts, own_req, others, lock_keep, keep;
      int best, bestd, d;
      if (!rd) return;
      lk        = LOCK_EN ? lk_in : 4'b0000;
      seqbusy   = (t == 2'b11) || (t == 2'b01);
      counts    = (t == 2'b10) || (t == 2'b11);
      own_req   = r[m_owner];
      others    = (r & ~(4'b0001 << m_owner)) != 4'b0000;
      lock_keep = lk[m_owner] && !m_parked;
      m_hmaster = m_owner;
      m_mlock   = lk[m_owner];
      keep = seqbusy || lock_keep || (own_req && (m_tenure < MAXT || !others));
      if (keep) begin
         if (counts && m_tenure < MAXT) m_tenure++;
         if (lock_keep || own_req) m_parked = 1'b0;
      end else begin
         best  = -1;
         bestd = N;
         for (int i = 0; i < N; i++) begin
            if (r[i]) begin
               d = (i - m_owner - 1 + 2 * N) % N;
               if (d < bestd) begin
                  bestd = d;
                  best  = i;
               end
            end
         end
         if (best < 0) begin
            best     = DEFM;
            m_parked = 1'b1;
         end else begin
            m_parked = 1'b0;
         end
         if (best != m_owner) m_tenure = 0;
         else if (counts && m_tenure < MAXT) m_tenure++;
         m_owner = best;
      end
   endtask

   task automatic check_model(input string nm);
      logic [3:0] eg;
      eg = 4'b0001 << m_owner;
      check({nm, "/hgrant"},    32'(bus.hgrant), 32'(eg));
      check({nm, "/hmaster"},   32'(bus.hmaster), 32'(m_hmaster));
      check({nm, "/hmastlock"}, 32'(bus.hmastlock), 32'(m_mlock));
      check({nm, "/onehot"},    32'($onehot(bus.hgrant)), 32'd1);
   endtask

   task automatic step(input string nm, input logic [3:0] r, input logic [1:0] t,
                       input logic rd, input logic [3:0] lk);
      bus.hbusreq = r;
      bus.htrans  = t;
      bus.hready  = rd;
`ifdef AHB_ARB_LOCK_EN
      bus.hlock = lk;
`endif
      @(posedge hclk);
      model_edge(r, t, rd, lk);
      #1;
      check_model(nm);
   endtask

   initial begin
      // Directed table: expected values worked out by hand from the rules.
      vecs[0]  = '{4'b0100, 2'b00, 1'b1, 4'b0100, 2'd0}; // request from parked
      vecs[1]  = '{4'b0100, 2'b00, 1'b1, 4'b0100, 2'd2}; // hmaster follows
      vecs[2]  = '{4'b0000, 2'b00, 1'b1, 4'b0001, 2'd2}; // back to park
      vecs[3]  = '{4'b1010, 2'b00, 1'b1, 4'b0010, 2'd0}; // 1 and 3, last 0 -> 1
      vecs[4]  = '{4'b1010, 2'b10, 1'b1, 4'b0010, 2'd1}; // 1 keeps
      vecs[5]  = '{4'b1000, 2'b10, 1'b1, 4'b1000, 2'd1}; // 1 drops -> 3
      vecs[6]  = '{4'b1010, 2'b10, 1'b1, 4'b1000, 2'd3}; // 3 keeps
      vecs[7]  = '{4'b0010, 2'b00, 1'b1, 4'b0010, 2'd3}; // 3 drops -> 1
      vecs[8]  = '{4'b0100, 2'b00, 1'b0, 4'b0010, 2'd3}; // wait states freeze
      vecs[9]  = '{4'b0100, 2'b00, 1'b0, 4'b0010, 2'd3};
      vecs[10] = '{4'b0100, 2'b00, 1'b0, 4'b0010, 2'd3};
      vecs[11] = '{4'b0100, 2'b00, 1'b1, 4'b0100, 2'd1}; // first ready edge
      vecs[12] = '{4'b0100, 2'b00, 1'b1, 4'b0100, 2'd2};

      hresetn     = 1'b0;
      bus.hbusreq = '0;
      bus.htrans  = 2'b00;
      bus.hready  = 1'b1;
`ifdef AHB_ARB_LOCK_EN
      bus.hlock = '0;
`endif
      model_reset();
      #12;
      check("reset/hgrant",    32'(bus.hgrant), 32'h1);
      check("reset/hmaster",   32'(bus.hmaster), 32'h0);
      check("reset/hmastlock", 32'(bus.hmastlock), 32'h0);
      @(negedge hclk);
      hresetn = 1'b1;

      foreach (vecs[i]) begin
         step($sformatf("vec%0d", i), vecs[i].req, vecs[i].trans, vecs[i].ready, 4'b0000);
         check($sformatf("vec%0d/tbl_grant", i), 32'(bus.hgrant), 32'(vecs[i].exp_grant));
         check($sformatf("vec%0d/tbl_hmaster", i), 32'(bus.hmaster), 32'(vecs[i].exp_hmaster));
      end

      // Tenure: master 1 streams while master 2 waits.
      step("ten_start", 4'b0010, 2'b00, 1'b1, 4'b0000);
      check("ten_start/grant", 32'(bus.hgrant), 32'h2);
      step("ten_nseq", 4'b0110, 2'b10, 1'b1, 4'b0000);
      for (int b = 0; b < 16; b++) begin
         step($sformatf("ten_seq%0d", b), 4'b0110, 2'b11, 1'b1, 4'b0000);
         check($sformatf("ten_seq%0d/grant", b), 32'(bus.hgrant), 32'h2);
      end
      step("ten_handover", 4'b0110, 2'b10, 1'b1, 4'b0000);
      check("ten_handover/grant", 32'(bus.hgrant), 32'h4);

      // Asynchronous reset in the middle of a burst.
      step("rst_nseq", 4'b0100, 2'b10, 1'b1, 4'b0000);
      step("rst_seq", 4'b0100, 2'b11, 1'b1, 4'b0000);
      #2;
      hresetn = 1'b0;
      #1;
      check("midrst/hgrant",    32'(bus.hgrant), 32'h1);
      check("midrst/hmaster",   32'(bus.hmaster), 32'h0);
      check("midrst/hmastlock", 32'(bus.hmastlock), 32'h0);
      model_reset();
      @(negedge hclk);
      hresetn = 1'b1;

`ifdef AHB_ARB_LOCK_EN
      // Locked owner ignores tenure expiry and the waiting master.
      step("lk_grant", 4'b0010, 2'b00, 1'b1, 4'b0000);
      for (int b = 0; b < 20; b++) begin
         step($sformatf("lk_beat%0d", b), 4'b0110, 2'b10, 1'b1, 4'b0010);
         check($sformatf("lk_beat%0d/grant", b), 32'(bus.hgrant), 32'h2);
         check($sformatf("lk_beat%0d/mastlock", b), 32'(bus.hmastlock), 32'h1);
      end
      step("lk_release", 4'b0110, 2'b00, 1'b1, 4'b0000);
      check("lk_release/grant", 32'(bus.hgrant), 32'h4);
`endif

      // Random traffic against the model.
      for (int c = 0; c < 400; c++) begin
         logic [3:0] r, lk;
         logic [1:0] t;
         logic       rd;
         r  = 4'($urandom_range(0, 15));
         t  = 2'($urandom_range(0, 3));
         rd = ($urandom_range(0, 9) < 8);
         lk = 4'b0000;
         if (LOCK_EN && $urandom_range(0, 5) == 0) lk = 4'($urandom_range(0, 15));
         step($sformatf("rnd%0d", c), r, t, rd, lk);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/ahb_arbiter.md
# ahb_arbiter

Round-robin bus arbiter for the AHB fabric. It shares the single AHB address/data path between up to four masters: it grants one requester at a time, drives `hmaster` to steer the master-side multiplexers, and holds ownership across bursts and locked sequences. It sits between the masters' request lines and the master mux, upstream of the address decoder that generates the slave `hsel` lines.

## Interface
- `NUM_MASTERS`, 4, number of requesting masters (2..4).
- `ID_W`, 2, width of `hmaster`; fixed at 2.
- `DEFAULT_MASTER`, 0, master parked on the bus when nobody requests.
- `MAX_TENURE`, 16, owner data beats before forced handover is allowed (2..255).

Ports:
- `hclk`  in  1  bus clock; all state on rising edge.
- `hresetn`  in  1  asynchronous, active-low reset.
- `hbusreq`  in  NUM_MASTERS  per-master bus request.
- `hlock`  in  NUM_MASTERS  per-master lock request (present only with `AHB_ARB_LOCK_EN`).
- `htrans`  in  2  transfer type of the current owner (post master mux).
- `hready`  in  1  transfer-complete from the slave mux.
- `hgrant`  out  NUM_MASTERS  one-hot grant, registered.
- `hmaster`  out  ID_W  id of the master owning the address phase, registered.
- `hmastlock`  out  1  current address phase is locked, registered.

## Operation
- States:
  - PARK: default master granted, no requests.
  - OWNED: a requester holds the grant.
  - LOCKED: owner holds a lock; exists only with the macro.
- Decision point: a rising edge with `hready`=1. With `hready`=0, every register holds (`hgrant`, `hmaster`, `hmastlock`, tenure counter, RR pointer).
- Hold conditions at a decision point. The owner keeps the grant if any of the following holds:
  - `htrans` is SEQ or BUSY (mid-burst);
  - state is LOCKED;
  - it still requests and (tenure < MAX_TENURE, or no other master requests).
- Otherwise, pick the next requester round-robin, searching from (last granted id + 1) modulo NUM_MASTERS. The owner is eligible only after all others.
- No requester → grant DEFAULT_MASTER and enter PARK.
- A new request in PARK is granted at the next decision point.
- The RR pointer updates to the new owner's id on every grant change.
- Tenure counter:
  - increments on each decision point where `htrans` is NONSEQ or SEQ;
  - saturates at MAX_TENURE;
  - clears to 0 on a grant change.
- Simultaneous events: if the owner drops `hbusreq` in the same cycle another master raises its request, the handover happens at that decision point.
- Reset mid-operation: all outputs and state return to reset values immediately, regardless of `hclk`.

## Timing
- Reset values: `hgrant` = one-hot DEFAULT_MASTER, `hmaster`=DEFAULT_MASTER, `hmastlock`=0, state PARK, tenure 0, RR pointer = DEFAULT_MASTER.
- Request to grant: `hbusreq` sampled at decision edge N; `hgrant` changes after edge N.
- Grant to `hmaster`: `hmaster` takes the granted id at the next decision edge after the grant change (one address phase later, per AHB handover).
- `hmastlock`: sampled with the same timing as `hmaster`, from the `hlock` bit of the granted master.
- `hgrant` is always exactly one-hot; never zero, never multi-hot.

## Configuration
- `AHB_ARB_LOCK_EN` defined:
  - the `hlock` port exists;
  - OWNED→LOCKED when the owner's `hlock`=1 at a decision point;
  - LOCKED→OWNED when `hlock` drops and `htrans` is not SEQ/BUSY;
  - LOCKED ignores tenure expiry and other requests.
- Not defined:
  - no `hlock` port and no LOCKED state;
  - `hmastlock` is tied 0.

## Structure
- Shared package `ahb_pkg` holds:
  - HTRANS encodings: IDLE=2'b00, BUSY=2'b01, NONSEQ=2'b10, SEQ=2'b11;
  - the master-id type;
  - the arbiter state enum.
- One sub-module, `ahb_rr_picker`: combinational round-robin priority picker (request vector + last id → one-hot grant, valid).

## Test plan
- Reset asserted mid-burst → `hgrant`=4'b0001, `hmaster`=0, `hmastlock`=0 immediately.
- `hbusreq`=4'b0100, `hready`=1, `htrans`=IDLE → `hgrant`=4'b0100 after 1 edge; `hmaster`=2 after the next edge.
- Masters 1 and 3 request, last owner 0 → grant 1. Master 1 drops at a NONSEQ boundary → grant 3. Master 1 re-requests, then 3 drops → grant 1.
- Master 1 streams SEQ with master 2 requesting → no handover through beat 16. Handover to 2 at the first decision point where tenure=16 and `htrans`=NONSEQ.
- `hready`=0 for 3 cycles while master 2 raises its request → `hgrant`/`hmaster` frozen. Change happens on the first `hready`=1 edge.
- With `AHB_ARB_LOCK_EN`: `hlock[1]`=1 while master 2 requests past tenure 16 → grant stays 4'b0010 and `hmastlock`=1. `hlock` drops with `htrans`=IDLE → grant 4'b0100.
